circ_buf_ptr_ctrl: RTL and testbench
====================================

# circ_buf_ptr_ctrl

Pointer and occupancy controller for a circular buffer of arbitrary (non-power-of-two) depth. It keeps independent write and read pointers that advance by configurable strides modulo DEPTH, and tracks occupancy. It generates full/empty, wrap and sticky overflow/underflow indications. It sits between a producer/consumer pair and the buffer RAM, and is the multi-pointer, multi-stride generalisation of the single-pointer circular-buffer counter.

## Interface
Parameters:
- DEPTH, 5: number of buffer entries; legal range ≥ 2, any integer.
- WPAR, 1: write stride, entries consumed per accepted push; 1 ≤ WPAR ≤ DEPTH.
- RPAR, 1: read stride, entries released per accepted pop; 1 ≤ RPAR ≤ DEPTH.
- PW, $clog2(DEPTH): pointer width (derived; do not override).
- CW, $clog2(DEPTH+1): count width (derived; do not override).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- clr  in  1  synchronous flush.
- push  in  1  write request.
- pop  in  1  read request.
- wptr  out  PW  write pointer, registered.
- rptr  out  PW  read pointer, registered.
- count  out  CW  occupied entries, registered.
- full  out  1  push would be refused.
- empty  out  1  pop would be refused.
- wwrap  out  1  one-cycle pulse: wptr wrapped.
- rwrap  out  1  one-cycle pulse: rptr wrapped.
- ovf  out  1  sticky: push refused.
- unf  out  1  sticky: pop refused.

## Operation
- Reset (rst=0, async):
  - wptr=rptr=count=0.
  - wwrap=rwrap=ovf=unf=0.
  - Hence empty=1 and full=(WPAR>DEPTH)=0.
- Flags are combinational from registered count:
  - full = count > DEPTH−WPAR.
  - empty = count < RPAR.
- Request acceptance:
  - push_ok = push & ~full.
  - pop_ok = pop & ~empty.
  - Both use the count value before the edge; there is no bypass, so a pop does not free room for a simultaneous push.
- Pointer update, shared rule: nxt = p + STEP, computed PW+1 bits wide. If nxt ≥ DEPTH, nxt −= DEPTH and the wrap pulse fires. A single subtraction suffices because STEP ≤ DEPTH.
- wptr advances by WPAR on push_ok. rptr advances by RPAR on pop_ok.
- count_next = count + (push_ok?WPAR:0) − (pop_ok?RPAR:0), computed CW+1 bits wide. It never leaves [0, DEPTH] by construction.
- ovf is set on push & full. unf is set on pop & empty. Both stay set until clr or reset.
- clr has priority over push/pop in the same cycle:
  - pointers, count, wrap pulses and sticky flags all go to 0;
  - requests in that cycle are ignored and do not set ovf/unf.
- Reset asserted mid-operation returns to the reset state immediately, with no clock needed.

## Timing
- All outputs except full/empty are registered. wptr/rptr/count reflect a request on the edge that samples it: latency 1.
- full/empty change in the same cycle as count (combinational decode).
- wwrap/rwrap are high for exactly the one cycle following the edge at which the pointer wrapped. Consecutive wrapping requests give consecutive pulses.
- ovf/unf rise in the cycle after the refused request.
- No handshake stall: requests are single-cycle and refused requests are dropped.

## Structure
- Sub-module circ_ptr_step:
  - parameters DEPTH, STEP;
  - ports clk, rst, clr, en, ptr, wrap;
  - implements the modular stride pointer plus its wrap pulse.
  - Instantiated twice (write: STEP=WPAR; read: STEP=RPAR).
- The top level holds the count register, flag decode and sticky flags.
- Shared header circ_buf_defs holds:
  - the PW/CW width derivation;
  - parameter legality checks (elaboration error when WPAR or RPAR is 0 or > DEPTH).

## Test plan
Configuration DEPTH=5, WPAR=2, RPAR=1 unless noted.
- Reset: after reset, wptr=rptr=count=0, empty=1, full=0, ovf=unf=0. Assert rst mid-run with count=3: outputs return to 0 before the next clock edge.
- Fill to full: two pushes give wptr 2 then 4, count 4, full=1. A third push is refused: wptr stays 4 and ovf=1 next cycle.
- Drain and wrap:
  - from count 4, three pops give rptr 1,2,3 and count 1;
  - then push: wptr=(4+2)−5=1, wwrap pulses for one cycle, count=3.
- Simultaneous push and pop:
  - at count 3, both accepted, count=4;
  - at count 4 (full), push refused, pop accepted, count=3, ovf set.
- Empty underflow: pop at count 0 leaves rptr unchanged and sets unf. clr with push=pop=1 zeroes everything and clears ovf/unf.
- Stride = depth corner (DEPTH=3, WPAR=RPAR=3):
  - every accepted push wraps wptr 0→0 with wwrap;
  - full=1 at count 3, empty=1 at count < 3.

Source files
------------

// File: rtl/circ_buf_ptr_ctrl_pkg.sv
// Shared definitions for the circular-buffer pointer controller:
// pointer/count width derivation and stride legality helpers.
package circ_buf_defs;

  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit stride_legal(input int depth, input int step);
    return (step >= 1) && (step <= depth);
  endfunction

endpackage

// File: rtl/circ_buf_ptr_ctrl_if.sv
// Producer/consumer-facing bundle of the circular-buffer pointer controller.
interface circ_buf_ptr_ctrl_if
  import circ_buf_defs::*;
#(
  parameter int DEPTH = 5,
  parameter int PW    = ptr_width(DEPTH),
  parameter int CW    = cnt_width(DEPTH)
);
  // Requests are single-cycle with no ready: push/pop are accepted on the edge
  // that samples them unless full/empty is high, and refused requests are dropped
  // (recorded only in the sticky ovf/unf flags).
  logic          push;
  logic          pop;
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          wwrap;
  logic          rwrap;
  logic          ovf;
  logic          unf;

  modport master (
    output push, pop,
    input  wptr, rptr, count, full, empty, wwrap, rwrap, ovf, unf
  );

  modport slave (
    input  push, pop,
    output wptr, rptr, count, full, empty, wwrap, rwrap, ovf, unf
  );
endinterface

// File: rtl/circ_buf_ptr_ctrl_step.sv
// Modular stride pointer: advances by STEP modulo DEPTH on en and pulses
// wrap for the cycle after an advance that crossed DEPTH.
module circ_ptr_step
  import circ_buf_defs::*;
#(
  parameter int DEPTH = 5,
  parameter int STEP  = 1,
  parameter int PW    = ptr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [PW-1:0] ptr,
  output logic          wrap
);

  if (DEPTH < 2) begin : g_bad_depth
    $error("circ_ptr_step: DEPTH must be at least 2");
  end
  if (!stride_legal(DEPTH, STEP)) begin : g_bad_step
    $error("circ_ptr_step: STEP must lie in 1..DEPTH");
  end

  localparam logic [PW:0] STEP_W  = (PW+1)'(STEP);
  localparam logic [PW:0] DEPTH_W = (PW+1)'(DEPTH);

  logic [PW:0]   sum;
  logic          wrap_nxt;
  logic [PW-1:0] ptr_nxt;

  // STEP <= DEPTH, so one conditional subtraction restores the range.
  always_comb begin
    sum      = {1'b0, ptr} + STEP_W;
    wrap_nxt = (sum >= DEPTH_W);
    ptr_nxt  = wrap_nxt ? PW'(sum - DEPTH_W) : sum[PW-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr  <= '0;
      wrap <= 1'b0;
    end else if (clr) begin
      ptr  <= '0;
      wrap <= 1'b0;
    end else if (en) begin
      ptr  <= ptr_nxt;
      wrap <= wrap_nxt;
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: rtl/circ_buf_ptr_ctrl.sv
// Pointer and occupancy controller for a circular buffer of any depth, with
// independent write/read strides, full/empty decode and sticky ovf/unf.
module circ_buf_ptr_ctrl
  import circ_buf_defs::*;
#(
  parameter int DEPTH = 5,
  parameter int WPAR  = 1,
  parameter int RPAR  = 1,
  parameter int PW    = ptr_width(DEPTH),
  parameter int CW    = cnt_width(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  circ_buf_ptr_ctrl_if.slave bus
);

  localparam logic [CW-1:0] WSTEP   = CW'(WPAR);
  localparam logic [CW-1:0] RSTEP   = CW'(RPAR);
  localparam logic [CW-1:0] FULL_TH = CW'(DEPTH - WPAR);

  logic [CW-1:0] count_q;
  logic          full;
  logic          empty;
  logic          push_ok;
  logic          pop_ok;
  logic          ovf_q;
  logic          unf_q;
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          wwrap;
  logic          rwrap;

  // Both decisions see the pre-edge count: a pop never makes room for a same-cycle push.
  assign full    = (count_q > FULL_TH);
  assign empty   = (count_q < RSTEP);
  assign push_ok = bus.push & ~full;
  assign pop_ok  = bus.pop & ~empty;

  circ_ptr_step #(.DEPTH(DEPTH), .STEP(WPAR), .PW(PW)) u_wptr (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .en   (push_ok),
    .ptr  (wptr),
    .wrap (wwrap)
  );

  circ_ptr_step #(.DEPTH(DEPTH), .STEP(RPAR), .PW(PW)) u_rptr (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .en   (pop_ok),
    .ptr  (rptr),
    .wrap (rwrap)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else if (clr) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_q + (push_ok ? WSTEP : '0) - (pop_ok ? RSTEP : '0);
      ovf_q   <= ovf_q | (bus.push & full);
      unf_q   <= unf_q | (bus.pop & empty);
    end
  end

  assign bus.wptr  = wptr;
  assign bus.rptr  = rptr;
  assign bus.count = count_q;
  assign bus.full  = full;
  assign bus.empty = empty;
  assign bus.wwrap = wwrap;
  assign bus.rwrap = rwrap;
  assign bus.ovf   = ovf_q;
  assign bus.unf   = unf_q;

endmodule

// File: tb/tb_circ_buf_ptr_ctrl.sv
// Directed bench for circ_buf_ptr_ctrl: DEPTH=5/WPAR=2/RPAR=1 main instance
// plus a DEPTH=3 stride-equals-depth instance.
module tb_circ_buf_ptr_ctrl;

  logic clk;
  logic rst;
  logic clr_a;
  logic clr_b;

  int n_checks;
  int n_fail;

  circ_buf_ptr_ctrl_if #(.DEPTH(5)) bus_a ();
  circ_buf_ptr_ctrl_if #(.DEPTH(3)) bus_b ();

  circ_buf_ptr_ctrl #(.DEPTH(5), .WPAR(2), .RPAR(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .clr (clr_a),
    .bus (bus_a.slave)
  );

  circ_buf_ptr_ctrl #(.DEPTH(3), .WPAR(3), .RPAR(3)) dut_b (
    .clk (clk),
    .rst (rst),
    .clr (clr_b),
    .bus (bus_b.slave)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic push, input logic pop, input logic clr);
    bus_a.push = push;
    bus_a.pop  = pop;
    clr_a      = clr;
    tick();
  endtask

  task automatic drive_b(input logic push, input logic pop);
    bus_b.push = push;
    bus_b.pop  = pop;
    tick();
  endtask

  task automatic check_a(input string tag, input int wp, input int rp, input int cnt,
                         input bit fl, input bit em, input bit ww, input bit rw,
                         input bit ov, input bit un);
    check({tag, ".wptr"},  32'(bus_a.wptr),  32'(wp));
    check({tag, ".rptr"},  32'(bus_a.rptr),  32'(rp));
    check({tag, ".count"}, 32'(bus_a.count), 32'(cnt));
    check({tag, ".full"},  32'(bus_a.full),  32'(fl));
    check({tag, ".empty"}, 32'(bus_a.empty), 32'(em));
    check({tag, ".wwrap"}, 32'(bus_a.wwrap), 32'(ww));
    check({tag, ".rwrap"}, 32'(bus_a.rwrap), 32'(rw));
    check({tag, ".ovf"},   32'(bus_a.ovf),   32'(ov));
    check({tag, ".unf"},   32'(bus_a.unf),   32'(un));
  endtask

  task automatic check_b(input string tag, input int wp, input int rp, input int cnt,
                         input bit fl, input bit em, input bit ww, input bit rw,
                         input bit ov);
    check({tag, ".wptr"},  32'(bus_b.wptr),  32'(wp));
    check({tag, ".rptr"},  32'(bus_b.rptr),  32'(rp));
    check({tag, ".count"}, 32'(bus_b.count), 32'(cnt));
    check({tag, ".full"},  32'(bus_b.full),  32'(fl));
    check({tag, ".empty"}, 32'(bus_b.empty), 32'(em));
    check({tag, ".wwrap"}, 32'(bus_b.wwrap), 32'(ww));
    check({tag, ".rwrap"}, 32'(bus_b.rwrap), 32'(rw));
    check({tag, ".ovf"},   32'(bus_b.ovf),   32'(ov));
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b0;
    clr_a      = 1'b0;
    clr_b      = 1'b0;
    bus_a.push = 1'b0;
    bus_a.pop  = 1'b0;
    bus_b.push = 1'b0;
    bus_b.pop  = 1'b0;

    tick();
    tick();
    //        tag         wp rp cnt full empty ww rw ovf unf
    check_a("reset",      0, 0, 0,  0,   1,    0, 0, 0,  0);
    check_b("reset_b",    0, 0, 0,  0,   1,    0, 0, 0);
    rst = 1'b1;
    tick();
    check_a("idle",       0, 0, 0,  0,   1,    0, 0, 0,  0);

    // fill to full, third push refused
    drive_a(1, 0, 0);
    check_a("push1",      2, 0, 2,  0,   0,    0, 0, 0,  0);
    drive_a(1, 0, 0);
    check_a("push2",      4, 0, 4,  1,   0,    0, 0, 0,  0);
    drive_a(1, 0, 0);
    check_a("push_ref",   4, 0, 4,  1,   0,    0, 0, 1,  0);

    // drain three, then a wrapping push
    drive_a(0, 1, 0);
    check_a("pop1",       4, 1, 3,  0,   0,    0, 0, 1,  0);
    drive_a(0, 1, 0);
    check_a("pop2",       4, 2, 2,  0,   0,    0, 0, 1,  0);
    drive_a(0, 1, 0);
    check_a("pop3",       4, 3, 1,  0,   0,    0, 0, 1,  0);
    drive_a(1, 0, 0);
    check_a("push_wrap",  1, 3, 3,  0,   0,    1, 0, 1,  0);
    drive_a(0, 0, 0);
    check_a("wwrap_end",  1, 3, 3,  0,   0,    0, 0, 1,  0);

    // simultaneous push/pop: both accepted, then push refused at full
    drive_a(1, 1, 0);
    check_a("both_ok",    3, 4, 4,  1,   0,    0, 0, 1,  0);
    drive_a(1, 1, 0);
    check_a("both_full",  3, 0, 3,  0,   0,    0, 1, 1,  0);

    // drain to empty, then underflow
    drive_a(0, 1, 0);
    check_a("drain1",     3, 1, 2,  0,   0,    0, 0, 1,  0);
    drive_a(0, 1, 0);
    drive_a(0, 1, 0);
    check_a("drain3",     3, 3, 0,  0,   1,    0, 0, 1,  0);
    drive_a(0, 1, 0);
    check_a("underflow",  3, 3, 0,  0,   1,    0, 0, 1,  1);

    // clear wins over simultaneous requests
    drive_a(1, 1, 1);
    check_a("clr",        0, 0, 0,  0,   1,    0, 0, 0,  0);
    drive_a(0, 0, 0);
    check_a("after_clr",  0, 0, 0,  0,   1,    0, 0, 0,  0);

    // asynchronous reset mid-run at count 3
    drive_a(1, 0, 0);
    drive_a(1, 0, 0);
    drive_a(0, 1, 0);
    check_a("pre_rst",    4, 1, 3,  0,   0,    0, 0, 0,  0);
    bus_a.pop = 1'b0;
    #1 rst = 1'b0;
    #1;
    check_a("async_rst",  0, 0, 0,  0,   1,    0, 0, 0,  0);
    tick();
    rst = 1'b1;
    tick();

    // stride equals depth (DEPTH=3, WPAR=RPAR=3)
    //        tag          wp rp cnt full empty ww rw ovf
    drive_b(1, 0);
    check_b("b_push",      0, 0, 3,  1,   0,    1, 0, 0);
    drive_b(1, 0);
    check_b("b_push_ref",  0, 0, 3,  1,   0,    0, 0, 1);
    drive_b(0, 1);
    check_b("b_pop",       0, 0, 0,  0,   1,    0, 1, 1);
    drive_b(1, 0);
    check_b("b_push2",     0, 0, 3,  1,   0,    1, 0, 1);
    drive_b(1, 1);
    check_b("b_both",      0, 0, 0,  0,   1,    0, 1, 1);
    drive_b(0, 0);
    check_b("b_idle",      0, 0, 0,  0,   1,    0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
